seg7_scan_decoder: RTL and testbench
====================================

// Module: seg7_scan_decoder
// PURPOSE
//   Receive-side counterpart of the hex-to-7-segment encoder. Monitors a time-multiplexed
//   display bus (active-low digit enables + active-low segments), qualifies each digit's
//   dwell, decodes the segment pattern back to a 4-bit nibble, and publishes whole frames.
//   Used as a self-check/readback monitor on the timer's display outputs.
// PARAMETERS
//   NUM_DIGITS     4   number of multiplexed digits (>=1)
//   STABLE_CYCLES  4   consecutive identical samples required before capture (>=2)
//   CNT_W          8   width of the stability counter; 2**CNT_W > STABLE_CYCLES
// PORTS
//   clk          in   1               system clock, all logic on rising edge
//   rst_n        in   1               asynchronous active-low reset
//   an           in   NUM_DIGITS      digit enables, active-low; an[i]=0 selects digit i
//   seg          in   7               segments, active-low; seg[6]=a ... seg[0]=g
//   value        out  4*NUM_DIGITS    last published frame; digit i at value[4i+3:4i]
//   digit_err    out  NUM_DIGITS      last published frame; 1 = digit i had an undecodable pattern
//   frame_valid  out  1               1-cycle pulse when value/digit_err update
// BEHAVIOUR
//   Reset: value=0, digit_err=0, frame_valid=0, shadow regs=0, captured mask=0,
//     stable_cnt=0, sample regs=all ones, FSM=COLLECT. Reset is immediate; a partial frame is discarded.
//   Sampling: {an,seg} registered every cycle (s_cur), previous sample kept (s_prev).
//   Stability: s_cur!=s_prev -> stable_cnt=0; else stable_cnt+1, saturating at STABLE_CYCLES.
//   Capture fires in the single cycle where s_cur==s_prev and stable_cnt==STABLE_CYCLES-2
//     (the tuple has been sampled STABLE_CYCLES times). No recapture until the tuple changes.
//   Capture only if an has exactly one bit low (digit i); all-ones or multi-low -> ignored.
//   Latency: tuple present at pins from cycle t -> shadow[i] written at edge ending cycle
//     t+STABLE_CYCLES.
//   Decode (seg[6:0] hex -> nibble): 01->0 4F->1 12->2 06->3 4C->4 24->5 20->6 0F->7
//     00->8 04->9 08->A 60->B 31->C 42->D 30->E 38->F. Any other pattern -> nibble 0, err=1.
//   Capture writes shadow_val[i], shadow_err[i], sets captured[i]. Recapturing a digit
//     already captured in the current frame overwrites its shadow (last dwell wins).
//   FSM COLLECT: when captured becomes all ones -> PUBLISH.
//   FSM PUBLISH (1 cycle): value<=shadow_val, digit_err<=shadow_err, frame_valid=1,
//     captured<=0 -> COLLECT. A capture in the PUBLISH cycle is for the next frame:
//     it writes the shadow and sets its captured bit after the clear (capture wins).
//   frame_valid is registered, high exactly 1 cycle per frame; value/digit_err hold between frames.
//   Outputs never change except in the PUBLISH-cycle update or on reset.
//   Digit order on the bus is arbitrary; frame completes on set coverage, not sequence.
// TESTING
//   Reset mid-dwell: assert rst_n=0 while digit 2 stable 3 cycles -> all outputs 0, no frame_valid.
//   Scan 4 digits each 6 cycles with seg 42,31,60,08 on an=1110,1101,1011,0111 -> one pulse,
//     value=16'hABCD, digit_err=0; repeat scan -> second pulse, same value.
//   Glitch: dwell of STABLE_CYCLES-1 cycles on digit 0 then change -> digit not captured,
//     no frame_valid until digit 0 is given a full dwell.
//   Bad pattern seg=7F on digit 1, others valid '5' (24) -> value=16'h5505, digit_err=4'b0010.
//   an=0000 and an=1111 held 20 cycles -> no captures, no frame_valid, outputs unchanged.
//   Exhaustive: for all 16 encoder outputs driven on digit 0 (NUM_DIGITS=1) -> value equals
//     encoder input, digit_err=0, one frame_valid pulse per distinct dwell.

Source files
------------

// File: rtl/seg7_scan_if.sv
// rtl/seg7_scan_if.sv - multiplexed 7-segment display bus plus decoded-frame readback
interface seg7_scan_if #(
   parameter int NUM_DIGITS = 4
);
   logic [NUM_DIGITS-1:0]   an;
   logic [6:0]              seg;
   logic [4*NUM_DIGITS-1:0] value;
   logic [NUM_DIGITS-1:0]   digit_err;
   logic                    frame_valid;

   modport master (
      output an, seg,
      input  value, digit_err, frame_valid
   );

   modport slave (
      input  an, seg,
      output value, digit_err, frame_valid
   );
endinterface

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - qualifies digit dwells on a scanned display bus and publishes decoded frames
module seg7_scan_decoder #(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   seg7_scan_if.slave  bus
);
   localparam int SW = NUM_DIGITS + 7;

   typedef enum logic {COLLECT, PUBLISH} state_t;

   state_t                  state;
   logic [SW-1:0]           s_cur;
   logic [SW-1:0]           s_prev;
   logic [CNT_W-1:0]        stable_cnt;
   logic [NUM_DIGITS-1:0]   captured;
   logic [NUM_DIGITS-1:0]   cap_sel;
   logic [4*NUM_DIGITS-1:0] shadow_val;
   logic [NUM_DIGITS-1:0]   shadow_err;
   logic                    same;
   logic                    capture;
   logic [4:0]              dec;

   function automatic logic [4:0] decode(input logic [6:0] s);
      logic [4:0] r;
      case (s)
         7'h01:   r = 5'h00;
         7'h4F:   r = 5'h01;
         7'h12:   r = 5'h02;
         7'h06:   r = 5'h03;
         7'h4C:   r = 5'h04;
         7'h24:   r = 5'h05;
         7'h20:   r = 5'h06;
         7'h0F:   r = 5'h07;
         7'h00:   r = 5'h08;
         7'h04:   r = 5'h09;
         7'h08:   r = 5'h0A;
         7'h60:   r = 5'h0B;
         7'h31:   r = 5'h0C;
         7'h42:   r = 5'h0D;
         7'h30:   r = 5'h0E;
         7'h38:   r = 5'h0F;
         default: r = 5'h10;
      endcase
      return r;
   endfunction

   // One capture per dwell: the counter saturates past the trigger value until the tuple changes.
   assign same    = (s_cur == s_prev);
   assign capture = same && (stable_cnt == CNT_W'(STABLE_CYCLES - 2));
   assign dec     = decode(s_cur[6:0]);

   always_comb begin
      cap_sel = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (capture && (s_cur[SW-1:7] == ~(NUM_DIGITS'(1) << i)))
            cap_sel[i] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= COLLECT;
         s_cur           <= '1;
         s_prev          <= '1;
         stable_cnt      <= '0;
         captured        <= '0;
         shadow_val      <= '0;
         shadow_err      <= '0;
         bus.value       <= '0;
         bus.digit_err   <= '0;
         bus.frame_valid <= 1'b0;
      end else begin
         s_cur  <= {bus.an, bus.seg};
         s_prev <= s_cur;
         if (!same)
            stable_cnt <= '0;
         else if (stable_cnt != CNT_W'(STABLE_CYCLES))
            stable_cnt <= stable_cnt + 1'b1;

         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap_sel[i]) begin
               shadow_val[4*i +: 4] <= dec[3:0];
               shadow_err[i]        <= dec[4];
            end
         end

         bus.frame_valid <= 1'b0;
         case (state)
            COLLECT: begin
               captured <= captured | cap_sel;
               if (&captured)
                  state <= PUBLISH;
            end
            PUBLISH: begin
               bus.value       <= shadow_val;
               bus.digit_err   <= shadow_err;
               bus.frame_valid <= 1'b1;
               // A capture landing here belongs to the next frame.
               captured        <= cap_sel;
               state           <= COLLECT;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - scoreboard bench for seg7_scan_decoder (4-digit and 1-digit instances)
module tb_seg7_scan_decoder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [19:0] q0[$];
   logic [4:0]  q1[$];
   logic [15:0] exp_val = '0;
   logic [3:0]  exp_err = '0;

   logic [6:0] enc [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                            7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

   seg7_scan_if #(.NUM_DIGITS(4)) bus0 ();
   seg7_scan_if #(.NUM_DIGITS(1)) bus1 ();

   seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4), .CNT_W(8)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
   seg7_scan_decoder #(.NUM_DIGITS(1), .STABLE_CYCLES(4), .CNT_W(8)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      logic [19:0] e0;
      logic [4:0]  e1;
      if (rst_n && bus0.frame_valid) begin
         checks++;
         assert (q0.size() > 0) else begin errors++; $error("FAIL unexpected_frame0 observed=1 expected=0"); end
         if (q0.size() > 0) begin
            e0 = q0.pop_front();
            checks++;
            assert (bus0.value === e0[15:0]) else begin
               errors++; $error("FAIL value0 observed=%h expected=%h", bus0.value, e0[15:0]); end
            checks++;
            assert (bus0.digit_err === e0[19:16]) else begin
               errors++; $error("FAIL digit_err0 observed=%b expected=%b", bus0.digit_err, e0[19:16]); end
         end
      end
      if (rst_n && bus1.frame_valid) begin
         checks++;
         assert (q1.size() > 0) else begin errors++; $error("FAIL unexpected_frame1 observed=1 expected=0"); end
         if (q1.size() > 0) begin
            e1 = q1.pop_front();
            checks++;
            assert (bus1.value === e1[3:0]) else begin
               errors++; $error("FAIL value1 observed=%h expected=%h", bus1.value, e1[3:0]); end
            checks++;
            assert (bus1.digit_err === e1[4]) else begin
               errors++; $error("FAIL digit_err1 observed=%b expected=%b", bus1.digit_err, e1[4]); end
         end
      end
   end

   task automatic step(input logic [3:0] a, input logic [6:0] s, input int n);
      bus0.an  = a;
      bus0.seg = s;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic dwell(input int d, input logic [6:0] s, input int n);
      step(~(4'b0001 << d), s, n);
   endtask

   task automatic scan(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                       input logic [6:0] s3, input logic [15:0] v, input logic [3:0] e);
      q0.push_back({e, v});
      exp_val = v;
      exp_err = e;
      dwell(0, s0, 6);
      dwell(1, s1, 6);
      dwell(2, s2, 6);
      dwell(3, s3, 6);
   endtask

   task automatic wait_done(input string tag);
      for (int k = 0; k < 30 && (q0.size() != 0 || q1.size() != 0); k++) @(posedge clk);
      #1;
      checks++;
      assert (q0.size() == 0 && q1.size() == 0) else begin
         errors++; $error("FAIL %s observed=%0d/%0d pending expected=0", tag, q0.size(), q1.size()); end
   endtask

   task automatic check_hold(input string tag);
      @(negedge clk);
      checks++;
      assert (bus0.value === exp_val && bus0.digit_err === exp_err && bus0.frame_valid === 1'b0) else begin
         errors++;
         $error("FAIL %s observed=%h/%b/%b expected=%h/%b/0", tag, bus0.value, bus0.digit_err,
                bus0.frame_valid, exp_val, exp_err);
      end
   endtask

   initial begin
      bus0.an = 4'hF; bus0.seg = 7'h7F;
      bus1.an = 1'b1; bus1.seg = 7'h7F;
      repeat (3) @(posedge clk);
      #1;
      check_hold("reset_state");
      checks++;
      assert (bus1.value === 4'h0 && bus1.digit_err === 1'b0 && bus1.frame_valid === 1'b0) else begin
         errors++; $error("FAIL reset_state1 observed=%h/%b/%b expected=0/0/0", bus1.value, bus1.digit_err, bus1.frame_valid); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      step(4'hF, 7'h7F, 3);

      scan(7'h42, 7'h31, 7'h60, 7'h08, 16'hABCD, 4'b0000);
      wait_done("frame_abcd");
      scan(7'h42, 7'h31, 7'h60, 7'h08, 16'hABCD, 4'b0000);
      wait_done("frame_abcd_repeat");
      check_hold("hold_abcd");

      dwell(0, 7'h4F, 6);
      dwell(1, 7'h12, 6);
      dwell(2, 7'h06, 3);
      rst_n = 1'b0;
      #1;
      exp_val = '0;
      exp_err = '0;
      check_hold("reset_mid_dwell");
      step(4'hF, 7'h7F, 2);
      rst_n = 1'b1;
      step(4'hF, 7'h7F, 3);
      check_hold("after_reset");

      scan(7'h24, 7'h7F, 7'h24, 7'h24, 16'h5505, 4'b0010);
      wait_done("frame_bad_pattern");

      step(4'h0, 7'h24, 20);
      check_hold("an_all_low");
      step(4'hF, 7'h24, 20);
      check_hold("an_all_high");

      dwell(1, 7'h12, 6);
      dwell(2, 7'h06, 6);
      dwell(3, 7'h4C, 6);
      dwell(0, 7'h4F, 3);
      step(4'hF, 7'h7F, 12);
      check_hold("glitch_no_frame");
      q0.push_back({4'b0000, 16'h4321});
      exp_val = 16'h4321;
      exp_err = 4'b0000;
      dwell(0, 7'h4F, 6);
      wait_done("frame_after_glitch");
      step(4'hF, 7'h7F, 4);
      check_hold("hold_4321");

      for (int k = 0; k < 16; k++) begin
         q1.push_back({1'b0, 4'(k)});
         bus1.an  = 1'b0;
         bus1.seg = enc[k];
         repeat (6) @(posedge clk);
         #1;
      end
      bus1.an  = 1'b1;
      bus1.seg = 7'h7F;
      wait_done("exhaustive_frames");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
